// File: rtl/fft_output_reorder_if.sv
// Sample-pair stream interface for the FFT output reorder buffer.
// Input side carries bit-reversed pairs, output side natural-order pairs.
interface fft_output_reorder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] x0;
    logic [DATA_WIDTH-1:0] x1;
    logic [DATA_WIDTH-1:0] y0;
    logic [DATA_WIDTH-1:0] y1;
    logic                  out_valid;
    logic                  out_last;

    modport master (
        output in_valid, x0, x1,
        input  y0, y1, out_valid, out_last
    );

    modport slave (
        input  in_valid, x0, x1,
        output y0, y1, out_valid, out_last
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: bit-reversed input pairs in,
// natural-order output pairs out, full rate, no backpressure.
module fft_output_reorder #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_output_reorder_if.slave  bus
);
    localparam int L  = $clog2(N);
    localparam int PW = L - 1;
    localparam logic [PW-1:0] LAST_P = PW'(N / 2 - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wp_q, wp_d;
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic [PW-1:0]         k_q, k_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] y0_q, y0_d;
    logic [DATA_WIDTH-1:0] y1_q, y1_d;
    logic                  ov_q, ov_d;
    logic                  ol_q, ol_d;

    logic [DATA_WIDTH-1:0] bank_q [2][N];

    logic                  done;
    logic [L-1:0]          wa0, wa1;
    logic [L-1:0]          ra0, ra1;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] a);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) begin
            r[i] = a[L-1-i];
        end
        return r;
    endfunction

    // Write side: pair counter, bank select and frame-complete detection
    always_comb begin
        wp_d = wp_q;
        wb_d = wb_q;
        done = bus.in_valid && (wp_q == LAST_P);
        wa0  = bitrev({wp_q, 1'b0});
        wa1  = bitrev({wp_q, 1'b1});
        if (bus.in_valid) begin
            if (done) begin
                wp_d = '0;
                wb_d = ~wb_q;
            end else begin
                wp_d = wp_q + 1'b1;
            end
        end
    end

    // Sample storage, indexed by natural bin; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && bus.in_valid) begin
            bank_q[wb_q][wa0] <= bus.x0;
            bank_q[wb_q][wa1] <= bus.x1;
        end
    end

    // Read side: drain one bank per frame, chaining a pending frame gaplessly
    always_comb begin
        state_d = state_q;
        rb_d    = rb_q;
        k_d     = k_q;
        pend_d  = pend_q;
        y0_d    = '0;
        y1_d    = '0;
        ov_d    = 1'b0;
        ol_d    = 1'b0;
        ra0     = {k_q, 1'b0};
        ra1     = {k_q, 1'b1};
        unique case (state_q)
            IDLE: begin
                if (done) begin
                    state_d = DRAIN;
                    rb_d    = wb_q;
                    k_d     = '0;
                end
            end
            DRAIN: begin
                y0_d = bank_q[rb_q][ra0];
                y1_d = bank_q[rb_q][ra1];
                ov_d = 1'b1;
                ol_d = (k_q == LAST_P);
                if (k_q == LAST_P) begin
                    k_d = '0;
                    if (pend_q || done) begin
                        rb_d   = ~rb_q;
                        pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                    if (done) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            k_q     <= '0;
            pend_q  <= 1'b0;
            y0_q    <= '0;
            y1_q    <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
        end
    end

    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.out_valid = ov_q;
    assign bus.out_last  = ol_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder: scheduled stimulus, frame-level
// reference model, per-cycle output comparison.
module tb_fft_output_reorder;
    localparam int N   = 8;
    localparam int DW  = 16;
    localparam int MAX = 1024;

    typedef logic [DW-1:0] frame_t [N];

    logic clk = 1'b0;
    logic reset = 1'b1;

    fft_output_reorder_if #(.DATA_WIDTH(DW)) bus ();

    fft_output_reorder #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic          s_rst [MAX];
    logic          s_v   [MAX];
    logic [DW-1:0] s_x0  [MAX];
    logic [DW-1:0] s_x1  [MAX];
    int            slen;

    logic          e_v  [MAX];
    logic          e_l  [MAX];
    logic [DW-1:0] e_y0 [MAX];
    logic [DW-1:0] e_y1 [MAX];

    function automatic int br(input int a);
        int r = 0;
        for (int b = 0; b < 3; b++) begin
            r = (r << 1) | ((a >> b) & 1);
        end
        return r;
    endfunction

    task automatic sched_clear();
        slen = 0;
    endtask

    task automatic sched_push(input logic r, input logic v,
                              input logic [DW-1:0] a,
                              input logic [DW-1:0] b);
        s_rst[slen] = r;
        s_v[slen]   = v;
        s_x0[slen]  = a;
        s_x1[slen]  = b;
        slen++;
    endtask

    // gapmode 0: no gaps, 1: one 0xFFFF gap between pairs, 2: random gaps
    task automatic sched_frame(input frame_t nat, input int gapmode);
        for (int p = 0; p < N / 2; p++) begin
            sched_push(1'b0, 1'b1, nat[br(2 * p)], nat[br(2 * p + 1)]);
            if (gapmode == 1 && p < N / 2 - 1) begin
                sched_push(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
            end else if (gapmode == 2) begin
                int g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) begin
                    sched_push(1'b0, 1'b0, DW'($urandom), DW'($urandom));
                end
            end
        end
    endtask

    function automatic frame_t ramp(input int base);
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = DW'(base + i);
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = DW'($urandom);
        return f;
    endfunction

    // Reference: gather valid pairs into frames by the bit-reversed index
    // rule; each frame drains N/2 edges, starting one edge after it completes
    // or right after the previous drain, whichever is later.
    task automatic build_expected();
        frame_t nat;
        int pairs = 0;
        int next_free = 0;
        for (int e = 0; e < MAX; e++) begin
            e_v[e] = 0; e_l[e] = 0; e_y0[e] = 0; e_y1[e] = 0;
        end
        for (int i = 0; i < N; i++) nat[i] = '0;
        for (int s = 0; s < slen; s++) begin
            int edge_n = s + 1;
            if (s_rst[s]) begin
                pairs = 0;
                next_free = 0;
                for (int e = edge_n; e < MAX; e++) begin
                    e_v[e] = 0; e_l[e] = 0; e_y0[e] = 0; e_y1[e] = 0;
                end
                continue;
            end
            if (s_v[s]) begin
                nat[br(2 * pairs)]     = s_x0[s];
                nat[br(2 * pairs + 1)] = s_x1[s];
                pairs++;
                if (pairs == N / 2) begin
                    int start = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
                    for (int k = 0; k < N / 2; k++) begin
                        e_v[start + k]  = 1'b1;
                        e_l[start + k]  = (k == N / 2 - 1);
                        e_y0[start + k] = nat[2 * k];
                        e_y1[start + k] = nat[2 * k + 1];
                    end
                    next_free = start + N / 2;
                    pairs = 0;
                end
            end
        end
    endtask

    task automatic drive_sched();
        for (int s = 0; s < slen; s++) begin
            reset        = s_rst[s];
            bus.in_valid = s_v[s];
            bus.x0       = s_x0[s];
            bus.x1       = s_x1[s];
            @(posedge clk);
            #1;
        end
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x0       = '0;
        bus.x1       = '0;
    endtask

    task automatic test_reset();
        sched_clear();
        for (int i = 0; i < 3; i++)
            sched_push(1'b1, 1'b1, DW'($urandom), DW'($urandom));
        for (int i = 0; i < 3; i++)
            sched_push(1'b0, 1'b0, DW'($urandom), DW'($urandom));
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL reset edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_single_frame();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        sched_frame(ramp(0), 0);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL single edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        sched_frame(ramp(0), 0);
        sched_frame(ramp(8), 0);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL b2b edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_input_gaps();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        sched_frame(ramp(0), 1);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL gaps edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_reset_mid_fill();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        sched_push(1'b0, 1'b1, 16'd0, 16'd4);
        sched_push(1'b0, 1'b1, 16'd2, 16'd6);
        sched_push(1'b1, 1'b0, '0, '0);
        sched_frame(ramp(20), 0);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL mid_fill edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    // Last pair in slot 4 (edge 5): outputs at edges 6,7...; reset sampled
    // at edge 7 kills the drain from its 2nd output cycle on.
    task automatic test_reset_mid_drain();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        sched_frame(rnd_frame(), 0);
        sched_push(1'b0, 1'b0, '0, '0);
        sched_push(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++)
            sched_push(1'b0, 1'b0, DW'($urandom), DW'($urandom));
        sched_frame(rnd_frame(), 0);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL mid_drain edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_pending();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        for (int f = 0; f < 4; f++) sched_frame(rnd_frame(), 0);
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL pending edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    task automatic test_random();
        sched_clear();
        sched_push(1'b1, 1'b0, '0, '0);
        for (int f = 0; f < 20; f++) begin
            sched_frame(rnd_frame(), ($urandom_range(0, 2) == 0) ? 0 : 2);
            if ($urandom_range(0, 7) == 0) begin
                sched_push(1'b0, 1'b1, DW'($urandom), DW'($urandom));
                sched_push(1'b1, 1'b1, DW'($urandom), DW'($urandom));
            end
        end
        build_expected();
        @(posedge clk); #1;
        fork
            drive_sched();
            for (int j = 1; j <= slen + 8; j++) begin
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.y0, bus.y1} !==
                    {e_v[j], e_l[j], e_y0[j], e_y1[j]}) begin
                    n_fail++;
                    $display("FAIL random edge %0d: got v=%b l=%b y=%h,%h want v=%b l=%b y=%h,%h",
                             j, bus.out_valid, bus.out_last, bus.y0, bus.y1,
                             e_v[j], e_l[j], e_y0[j], e_y1[j]);
                end
            end
        join
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.x0       = '0;
        bus.x1       = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_gaps();
        test_reset_mid_fill();
        test_reset_mid_drain();
        test_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
